clb_cfg_loader: RTL and testbench
=================================

Name: clb_cfg_loader

Overview:
- Serial configuration loader that sits directly upstream of the CLB tile.
- Hunts a 1-bit configuration stream for a sync word, then captures one 37-bit configuration frame and checks its parity.
- On a good frame it drives the CLB configuration fields: LUT memory, combinational option, mux selects, DQ muxes and flop/latch select.
- The CLB's configuration registers are driven from the CFG bus instead of fixed power-on values.

Parameters:
- SYNC_W, 8, sync word width in bits.
- SYNC_WORD, 8'hB5, sync pattern; matched MSB first.
- CFG_W, 37, configuration frame payload width. Fixed by the CLB field map; not to be overridden.
- CFG_RST, 37'h0_380A_8116, CFG value after reset. Equals the CLB power-on configuration.

Ports:
- K  input  1  clock; all logic on posedge K.
- RST  input  1  synchronous active-high reset.
- DIN  input  1  serial configuration bit.
- DIN_VALID  input  1  DIN is sampled only in cycles where DIN_VALID=1.
- CFG  output  CFG_W  applied configuration. Field map:
  - [15:0] mem, [17:16] comboption
  - [19:18] mux2select, [21:20] mux3select, [23:22] mux4select, [25:24] mux5select, [27:26] mux6select
  - [28] o2m1_0, [29] o2m2_0, [30] o2m3_0, [31] o2m1_1, [32] o2m2_1, [33] o2m3_1
  - [34] DQmux1, [35] DQmux2, [36] floporlatch
- CFG_UPDATE  output  1  one-cycle pulse when CFG changes from a good frame.
- BUSY  output  1  high while in LOAD or PAR state.
- ERR  output  1  sticky parity error flag.
- FRAMES  output  8  count of good frames; wraps 255->0.

Behaviour:
- Reset:
  - RST is sampled on posedge K; a reset cycle overrides all other inputs.
  - Values after reset: state=HUNT, sync shifter=0, bit counter=0, shadow=0, CFG=CFG_RST, CFG_UPDATE=0, BUSY=0, ERR=0, FRAMES=0.
  - RST asserted mid-frame discards the partial frame and returns CFG to CFG_RST.
- Cycles with DIN_VALID=0: no state, counter or shifter change. Gaps between valid bits may be of any length; there is no timeout.
- HUNT:
  - Each valid bit shifts into the SYNC_W-bit shifter: shifter <= {shifter[SYNC_W-2:0], DIN}.
  - If the post-shift value equals SYNC_WORD, go to LOAD with bit counter=CFG_W-1.
  - BUSY=0 in HUNT.
- LOAD:
  - Each valid bit is written to shadow[counter], so data arrives MSB first (bit 36 first).
  - A running even-parity accumulator XORs in each bit.
  - When the bit at counter=0 is accepted, go to PAR.
- PAR:
  - The next valid bit is the parity bit; the frame is good if accumulator XOR DIN = 0 (even parity over 38 bits).
  - Good frame, in the following cycle: CFG <= shadow, CFG_UPDATE=1 for exactly one cycle, FRAMES increments, ERR clears.
  - Bad frame, in the following cycle: CFG is unchanged, ERR=1 (sticky), CFG_UPDATE stays 0.
  - Either way, return to HUNT with the sync shifter cleared to 0, so frame bits never seed a sync match. The accumulator is cleared.
- Latency: CFG and CFG_UPDATE change exactly 1 K cycle after the cycle the parity bit is accepted.
- CFG never changes mid-frame. The CLB sees only whole, parity-checked configurations.
- Back-to-back frames: a sync word may begin on the first valid bit after a parity bit. The minimum frame is 46 valid bits.
- FRAMES wraps from 255 to 0 with no flag.
- All outputs are registered.

Test Plan:
- Reset check: hold RST for 2 cycles -> CFG=37'h0_380A_8116, ERR=0, BUSY=0, FRAMES=0, CFG_UPDATE=0.
- Good frame:
  - Stimulus: continuous valid bits 0xB5, then payload 37'h0_0000_FFFF MSB first, then parity 0.
  - Required: BUSY=1 from the cycle after the last sync bit through the parity bit; 1 cycle after the parity bit, CFG=37'h0_0000_FFFF, CFG_UPDATE pulses once, FRAMES=1.
- Bad parity: the same frame with parity 1 -> CFG stays 37'h0_380A_8116, ERR=1, FRAMES=0. A following good frame clears ERR and sets FRAMES=1.
- Gappy stream: the good frame with DIN_VALID=0 inserted after every 3rd valid bit, gaps 1-5 cycles long -> identical CFG result; no state change during gaps.
- Reset mid-frame: assert RST after 20 payload bits -> state HUNT, CFG=CFG_RST. A complete new frame then loads correctly.
- False sync:
  - Stimulus: preamble 0x5A, 0xB5 embedded after 3 junk bits; then a frame whose payload contains 0xB5, followed directly by a second frame.
  - Required: lock only on the true 0xB5; the payload 0xB5 does not re-sync; the second frame is applied; FRAMES=2.

Source files
------------

// File: rtl/clb_cfg_loader_if.sv
// Bus between the serial configuration source and the CLB configuration loader.
// The master side drives the serial bit stream. The slave side is the loader,
// which returns the applied configuration and its status.
interface clb_cfg_loader_if #(
  parameter int CFG_W = 37
);
  logic             DIN;
  logic             DIN_VALID;
  logic [CFG_W-1:0] CFG;
  logic             CFG_UPDATE;
  logic             BUSY;
  logic             ERR;
  logic [7:0]       FRAMES;

  modport master (
    output DIN, DIN_VALID,
    input  CFG, CFG_UPDATE, BUSY, ERR, FRAMES
  );

  modport slave (
    input  DIN, DIN_VALID,
    output CFG, CFG_UPDATE, BUSY, ERR, FRAMES
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader.
// It searches the bit stream for a sync word and then captures a 37-bit frame,
// MSB first, into a shadow register. It then checks one even-parity bit.
// The CLB configuration is updated only when a frame passes this check, so the
// tile never sees a partial or corrupted configuration.
module clb_cfg_loader #(
  parameter int               SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hB5,
  parameter int               CFG_W     = 37,
  parameter logic [CFG_W-1:0]  CFG_RST   = 37'h0_380A_8116
) (
  input logic K,
  input logic RST,
  clb_cfg_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CFG_W);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOAD = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state_q;
  logic [SYNC_W-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CFG_W-1:0]  shadow_q;
  logic              par_q;
  logic [CFG_W-1:0]  cfg_q;
  logic              cfg_update_q;
  logic              busy_q;
  logic              err_q;
  logic [7:0]        frames_q;

  // Shifter value that results if the current valid bit is taken in HUNT.
  logic [SYNC_W-1:0] sync_d;
  assign sync_d = {sync_q[SYNC_W-2:0], bus.DIN};

  // Sequencing for hunt, load and parity, with all outputs registered.
  // Cycles where DIN_VALID is low leave every register unchanged, except
  // the update pulse, which lasts a single cycle.
  always_ff @(posedge K) begin
    if (RST) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      par_q        <= 1'b0;
      cfg_q        <= CFG_RST;
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      frames_q     <= '0;
    end else begin
      cfg_update_q <= 1'b0;
      if (bus.DIN_VALID) begin
        case (state_q)
          HUNT: begin
            sync_q <= sync_d;
            if (sync_d == SYNC_WORD) begin
              state_q <= LOAD;
              cnt_q   <= CNT_W'(CFG_W - 1);
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            shadow_q[cnt_q] <= bus.DIN;
            par_q           <= par_q ^ bus.DIN;
            if (cnt_q == '0) begin
              state_q <= PAR;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          PAR: begin
            if ((par_q ^ bus.DIN) == 1'b0) begin
              cfg_q        <= shadow_q;
              cfg_update_q <= 1'b1;
              frames_q     <= frames_q + 8'd1;
              err_q        <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
            // Clear the shifter so that frame bits cannot seed a false sync.
            state_q <= HUNT;
            sync_q  <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= HUNT;
            sync_q  <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.CFG        = cfg_q;
  assign bus.CFG_UPDATE = cfg_update_q;
  assign bus.BUSY       = busy_q;
  assign bus.ERR        = err_q;
  assign bus.FRAMES     = frames_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader.
// The driver moves the input stream forward one clock at a time. After each
// clock edge it advances a queue-based reference model and pushes the outputs
// it expects into a scoreboard. A separate monitor pops those outputs on the
// falling edge and compares them with the DUT.
module tb_clb_cfg_loader;

  localparam int CFG_W = 37;
  localparam logic [CFG_W-1:0] CFG_RST = 37'h0_380A_8116;
  localparam logic [7:0] SYNC = 8'hB5;

  typedef struct {
    logic [CFG_W-1:0] cfg;
    logic             upd;
    logic             busy;
    logic             err;
    logic [7:0]       frames;
  } exp_t;

  bit   clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  clb_cfg_loader_if #(.CFG_W(CFG_W)) bus ();

  clb_cfg_loader dut (
    .K   (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state. It keeps the last 8 stream bits while searching
  // and the payload bits collected so far once locked.
  logic             m_locked;
  logic             m_win[$];
  logic             m_pay[$];
  logic [CFG_W-1:0] m_cfg;
  logic             m_err;
  logic [7:0]       m_frames;

  function automatic void model_step(input logic r, input logic v, input logic d);
    exp_t e;
    logic [7:0] w;
    int ones;
    logic upd;
    upd = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_win.delete();
      m_pay.delete();
      m_cfg    = CFG_RST;
      m_err    = 1'b0;
      m_frames = 8'd0;
    end else if (v) begin
      if (!m_locked) begin
        m_win.push_back(d);
        if (m_win.size() > 8) void'(m_win.pop_front());
        if (m_win.size() == 8) begin
          for (int i = 0; i < 8; i++) w[7-i] = m_win[i];
          if (w == SYNC) begin
            m_locked = 1'b1;
            m_pay.delete();
          end
        end
      end else if (m_pay.size() < CFG_W) begin
        m_pay.push_back(d);
      end else begin
        ones = int'(d);
        foreach (m_pay[i]) ones += int'(m_pay[i]);
        if (ones % 2 == 0) begin
          for (int i = 0; i < CFG_W; i++) m_cfg[CFG_W-1-i] = m_pay[i];
          upd      = 1'b1;
          m_frames = m_frames + 8'd1;
          m_err    = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_locked = 1'b0;
        m_win.delete();
        m_pay.delete();
      end
    end
    e.cfg    = m_cfg;
    e.upd    = upd;
    e.busy   = m_locked;
    e.err    = m_err;
    e.frames = m_frames;
    sb.push_back(e);
  endfunction

  // Monitor: every cycle, compare the DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.CFG !== e.cfg) begin
        errors++;
        $display("FAIL cfg t=%0t got=%h exp=%h", $time, bus.CFG, e.cfg);
      end
      checks++;
      if (bus.CFG_UPDATE !== e.upd) begin
        errors++;
        $display("FAIL cfg_update t=%0t got=%b exp=%b", $time, bus.CFG_UPDATE, e.upd);
      end
      checks++;
      if (bus.BUSY !== e.busy) begin
        errors++;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, bus.BUSY, e.busy);
      end
      checks++;
      if (bus.ERR !== e.err) begin
        errors++;
        $display("FAIL err t=%0t got=%b exp=%b", $time, bus.ERR, e.err);
      end
      checks++;
      if (bus.FRAMES !== e.frames) begin
        errors++;
        $display("FAIL frames t=%0t got=%0d exp=%0d", $time, bus.FRAMES, e.frames);
      end
      if (e.upd) $display("frame applied t=%0t cfg=%h frames=%0d", $time, e.cfg, e.frames);
    end
  end

  task automatic step(input logic r, input logic v, input logic d);
    rst           = r;
    bus.DIN_VALID = v;
    bus.DIN       = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
  endtask

  // gap_mode 0: no gaps; 1: 1-5 idle cycles after every 3rd valid bit;
  // 2: random idle cycles.
  int nvalid = 0;
  task automatic send_bit(input logic b, input int gap_mode);
    step(1'b0, 1'b1, b);
    nvalid++;
    if (gap_mode == 1 && nvalid % 3 == 0) begin
      repeat ($urandom_range(5, 1)) step(1'b0, 1'b0, $urandom_range(1, 0));
    end else if (gap_mode == 2 && $urandom_range(3, 0) == 0) begin
      repeat ($urandom_range(4, 1)) step(1'b0, 1'b0, $urandom_range(1, 0));
    end
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] p, input logic bad, input int gap_mode);
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], gap_mode);
    for (int i = CFG_W - 1; i >= 0; i--) send_bit(p[i], gap_mode);
    send_bit((^p) ^ bad, gap_mode);
  endtask

  initial begin
    logic [7:0] pre;
    logic [CFG_W-1:0] p;
    rst = 1'b1;
    bus.DIN = 1'b0;
    bus.DIN_VALID = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn reset done");

    send_frame(37'h0_0000_FFFF, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn good frame sent");

    step(1'b1, 1'b0, 1'b0);
    send_frame(37'h0_0000_FFFF, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn bad-parity frame sent");
    send_frame(37'h0_0000_FFFF, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn recovery frame sent");

    send_frame(37'h1_2345_6789, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0);
    $display("txn gappy frame sent");

    p = 37'h0_0F0F_0F0F;
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 0);
    for (int i = CFG_W - 1; i >= CFG_W - 20; i--) send_bit(p[i], 0);
    step(1'b1, 1'b0, 1'b0);
    send_frame(37'h0_ABCD_1234, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn reset mid-frame then frame sent");

    step(1'b1, 1'b0, 1'b0);
    pre = 8'h5A;
    for (int i = 7; i >= 0; i--) send_bit(pre[i], 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_frame(37'h0_B5B5_B5B5, 1'b0, 0);
    send_frame(37'h1_5555_AAAA, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn false-sync sequence sent");

    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(6, 0)) send_bit($urandom_range(1, 0), 2);
      p = {$urandom_range(31, 0), $urandom()};
      send_frame(p, ($urandom_range(3, 0) == 0), 2);
      $display("txn random frame %0d payload=%h", f, p);
    end

    for (int f = 0; f < 260; f++) send_frame({$urandom_range(31, 0), $urandom()}, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    $display("txn frame counter wrap run sent");

    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
